// File: rtl/adsr_pkg.sv
// ADSR envelope shared types: state encoding, level width and saturating step helpers.
// Latency: none (types and pure functions only).
// Backpressure: none (no handshaked interfaces).
package adsr_pkg;

    localparam int                 LEVEL_W   = 8;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 8'd255;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } adsr_state_t;

    function automatic logic [LEVEL_W-1:0] level_inc_sat(input logic [LEVEL_W-1:0] lvl);
        return (lvl == LEVEL_MAX) ? LEVEL_MAX : lvl + 1'b1;
    endfunction

    function automatic logic [LEVEL_W-1:0] level_dec_sat(input logic [LEVEL_W-1:0] lvl,
                                                        input logic [LEVEL_W-1:0] amt);
        return (lvl > amt) ? lvl - amt : '0;
    endfunction

endpackage

// File: rtl/adsr_duty_ctrl_period_cnt.sv
// Free-running PWM period counter; tick is high while the count sits at period_in-1.
// Latency: tick is combinational from the count register, one cycle wide every period_in cycles.
// Backpressure: none; always counts.
module adsr_duty_ctrl_period_cnt #(
    parameter int period_in = 256
) (
    input  logic clk_in,
    input  logic rst_in,
    output logic tick
);

    localparam int CNT_W = (period_in > 1) ? $clog2(period_in) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(period_in - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/adsr_duty_ctrl.sv
// ADSR envelope sequencer driving one PWM voice's duty and gate; EXP_RELEASE_EN selects an exponential release tail.
// Latency: note events act on the next edge; the level moves only on PWM-period ticks.
// Backpressure: none; note pulses are consumed every cycle, dc_out holds steady between ticks.
module adsr_duty_ctrl
    import adsr_pkg::*;
#(
    parameter int PERIOD = 256
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               note_on_in,
    input  logic               note_off_in,
    input  logic [LEVEL_W-1:0] attack_rate_in,
    input  logic [LEVEL_W-1:0] decay_rate_in,
    input  logic [LEVEL_W-1:0] sustain_in,
    input  logic [LEVEL_W-1:0] release_rate_in,
    output logic [LEVEL_W-1:0] dc_out,
    output logic               gate_out,
    output logic [2:0]         state_out
);

    logic               tick;
    adsr_state_t        state, state_nxt;
    logic [LEVEL_W-1:0] level, level_nxt;
    logic [LEVEL_W-1:0] rate_cnt, rate_cnt_nxt;
    logic [LEVEL_W-1:0] cur_rate;
    logic [LEVEL_W-1:0] rate_cnt_adv;
    logic [LEVEL_W-1:0] rel_amt;
    logic [LEVEL_W-1:0] cand;
    logic               rate_hit;
    logic               ev_release;
    logic               ev_attack;
    logic               gate;

    adsr_duty_ctrl_period_cnt #(
        .period_in (PERIOD)
    ) u_period_cnt (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .tick   (tick)
    );

    always_comb begin
        cur_rate = '0;
        case (state)
            ATTACK:  cur_rate = attack_rate_in;
            DECAY:   cur_rate = decay_rate_in;
            RELEASE: cur_rate = release_rate_in;
            default: cur_rate = '0;
        endcase
    end

    // Rates are read live, so a rate dropped below rate_cnt steps on the very next tick.
    assign rate_hit     = ({1'b0, rate_cnt} + 9'd1) >= {1'b0, cur_rate};
    assign rate_cnt_adv = rate_hit ? '0 : level_inc_sat(rate_cnt);

`ifdef EXP_RELEASE_EN
    assign rel_amt = ((level >> 3) == '0) ? LEVEL_W'(1) : (level >> 3);
`else
    assign rel_amt = LEVEL_W'(1);
`endif

    // note_off wins a same-cycle conflict; retrigger keeps the current level.
    assign ev_release = note_off_in && (state == ATTACK || state == DECAY || state == SUSTAIN);
    assign ev_attack  = !note_off_in && note_on_in && (state != ATTACK);

    always_comb begin
        state_nxt    = state;
        level_nxt    = level;
        rate_cnt_nxt = rate_cnt;
        cand         = level;
        if (ev_release) begin
            state_nxt    = RELEASE;
            rate_cnt_nxt = '0;
        end else if (ev_attack) begin
            state_nxt    = ATTACK;
            rate_cnt_nxt = '0;
            if (state == IDLE) begin
                level_nxt = '0;
            end
        end else if (tick) begin
            case (state)
                IDLE: begin
                    level_nxt    = '0;
                    rate_cnt_nxt = '0;
                end
                ATTACK: begin
                    if (attack_rate_in == '0) begin
                        cand = LEVEL_MAX;
                    end else if (rate_hit) begin
                        cand = level_inc_sat(level);
                    end
                    level_nxt = cand;
                    if (cand == LEVEL_MAX) begin
                        state_nxt    = DECAY;
                        rate_cnt_nxt = '0;
                    end else begin
                        rate_cnt_nxt = rate_cnt_adv;
                    end
                end
                DECAY: begin
                    if (decay_rate_in == '0) begin
                        cand = sustain_in;
                    end else if (rate_hit) begin
                        cand = level_dec_sat(level, LEVEL_W'(1));
                    end
                    if (cand <= sustain_in) begin
                        level_nxt    = sustain_in;
                        state_nxt    = SUSTAIN;
                        rate_cnt_nxt = '0;
                    end else begin
                        level_nxt    = cand;
                        rate_cnt_nxt = rate_cnt_adv;
                    end
                end
                SUSTAIN: begin
                    level_nxt    = sustain_in;
                    rate_cnt_nxt = '0;
                end
                RELEASE: begin
                    if (release_rate_in == '0) begin
                        cand = '0;
                    end else if (rate_hit) begin
                        cand = level_dec_sat(level, rel_amt);
                    end
                    level_nxt = cand;
                    if (cand == '0) begin
                        state_nxt    = IDLE;
                        rate_cnt_nxt = '0;
                    end else begin
                        rate_cnt_nxt = rate_cnt_adv;
                    end
                end
                default: begin
                    state_nxt    = IDLE;
                    level_nxt    = '0;
                    rate_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= IDLE;
            level    <= '0;
            rate_cnt <= '0;
            gate     <= 1'b0;
        end else begin
            state    <= state_nxt;
            level    <= level_nxt;
            rate_cnt <= rate_cnt_nxt;
            gate     <= (state_nxt != IDLE);
        end
    end

    assign dc_out    = level;
    assign gate_out  = gate;
    assign state_out = state;

endmodule
